rx_fir_coef_reload_ctrl: RTL and testbench

- Sequences run-time coefficient reloads into the four Rx decimation filters: half-band 0/1/2 and the pulse-shaping filter.
- Fetches a selected coefficient set from an external coefficient ROM and drives the selected filter's reload channel (coef_ld/coef_we/coef_din).
- Gates that filter's nd input during the reload and for a flush window afterwards, so the datapath never passes samples filtered with mixed coefficients.
- Sits beside the Rx filter chain and is driven by the control/register block.

---
 rtl/rx_fir_coef_reload_ctrl.sv | 150 +++++++++++++++
 tb/tb_rx_fir_coef_reload_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fir_coef_reload_ctrl.sv
// Rx FIR coefficient reload sequencer: fetches a coefficient set from ROM, streams it
// into the selected filter's reload channel and gates that filter's nd until flushed.
module rx_fir_coef_reload_ctrl #(
  parameter int unsigned NUM_FIR      = 4,
  parameter int unsigned COEF_WIDTH   = 18,
  parameter int unsigned MAX_TAPS     = 64,
  parameter int unsigned ROM_LAT      = 2,
  parameter int unsigned FLUSH_CYCLES = 64
) (
  input  logic                  logic_clk_in,
  input  logic                  logic_rst_n_in,
  input  logic                  reload_req_in,
  input  logic [1:0]            reload_sel_in,
  input  logic [1:0]            reload_set_in,
  input  logic [6:0]            reload_taps_in,
  output logic                  reload_busy_out,
  output logic                  reload_done_out,
  output logic                  reload_err_out,
  output logic                  coef_rom_rd_out,
  output logic [9:0]            coef_rom_addr_out,
  input  logic [COEF_WIDTH-1:0] coef_rom_data_in,
  output logic [NUM_FIR-1:0]    coef_ld_out,
  output logic [NUM_FIR-1:0]    coef_we_out,
  output logic [COEF_WIDTH-1:0] coef_din_out,
  output logic [NUM_FIR-1:0]    nd_gate_out
);

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned SET_W   = 2;
  localparam int unsigned TAPS_W  = 7;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned FLUSH_W = 8;

  typedef enum logic [2:0] {IDLE, GATE, LOAD, READ, DRAIN, FLUSH} state_t;

  state_t              state;
  logic [SEL_W-1:0]    sel_q;
  logic [SET_W-1:0]    set_q;
  logic [TAPS_W-1:0]   taps_q;
  logic [TAPS_W-1:0]   cnt;
  logic [TAPS_W-1:0]   next_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [ROM_LAT-1:0]  rd_pipe;
  logic [ROM_LAT-1:0]  last_pipe;
  logic                issue;
  logic                issue_last;
  logic [IDX_W-1:0]    issue_idx;
  logic                cap;
  logic                last_cap;
  logic                taps_bad;
  logic [NUM_FIR-1:0]  sel_onehot;

  assign sel_onehot = NUM_FIR'(1) << sel_q;
  assign cap        = rd_pipe[ROM_LAT-1];
  assign last_cap   = last_pipe[ROM_LAT-1];
  assign taps_bad   = (reload_taps_in == '0) || (reload_taps_in > TAPS_W'(MAX_TAPS));

  // Address issue: one ROM read per cycle from LOAD exit until taps addresses are out
  always_comb begin
    issue     = 1'b0;
    next_cnt  = cnt + TAPS_W'(1);
    issue_idx = cnt[IDX_W-1:0];
    if (state == LOAD) begin
      issue     = 1'b1;
      next_cnt  = TAPS_W'(1);
      issue_idx = '0;
    end else if ((state == READ) && (cnt != taps_q)) begin
      issue = 1'b1;
    end
    issue_last = issue && (next_cnt == taps_q);
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      state             <= IDLE;
      sel_q             <= '0;
      set_q             <= '0;
      taps_q            <= '0;
      cnt               <= '0;
      flush_cnt         <= '0;
      rd_pipe           <= '0;
      last_pipe         <= '0;
      reload_busy_out   <= 1'b0;
      reload_done_out   <= 1'b0;
      reload_err_out    <= 1'b0;
      coef_rom_rd_out   <= 1'b0;
      coef_rom_addr_out <= '0;
      coef_ld_out       <= '0;
      coef_we_out       <= '0;
      coef_din_out      <= '0;
      nd_gate_out       <= '1;
    end else begin
      reload_done_out <= 1'b0;
      reload_err_out  <= 1'b0;
      coef_ld_out     <= '0;
      flush_cnt       <= '0;
      coef_rom_rd_out <= issue;
      // Tracks which cycles carry valid ROM data and which one is the final word
      rd_pipe         <= (rd_pipe << 1) | ROM_LAT'(issue);
      last_pipe       <= (last_pipe << 1) | ROM_LAT'(issue_last);
      if (issue) begin
        coef_rom_addr_out <= {set_q, sel_q, issue_idx};
        cnt               <= next_cnt;
      end
      coef_we_out <= cap ? sel_onehot : '0;
      if (cap) coef_din_out <= coef_rom_data_in;

      case (state)
        IDLE: begin
          if (reload_req_in) begin
            sel_q  <= reload_sel_in;
            set_q  <= reload_set_in;
            taps_q <= reload_taps_in;
            if (taps_bad) begin
              reload_err_out <= 1'b1;
            end else begin
              state           <= GATE;
              reload_busy_out <= 1'b1;
              nd_gate_out     <= ~(NUM_FIR'(1) << reload_sel_in);
            end
          end
        end
        GATE: begin
          coef_ld_out <= sel_onehot;
          state       <= LOAD;
        end
        LOAD: state <= READ;
        READ: begin
          // With a 1-cycle ROM the final write lands on the same edge reads finish
          if (cnt == taps_q) state <= last_cap ? FLUSH : DRAIN;
        end
        DRAIN: begin
          if (last_cap) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(FLUSH_CYCLES)) begin
            state           <= IDLE;
            reload_busy_out <= 1'b0;
            reload_done_out <= 1'b1;
            nd_gate_out     <= '1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_fir_coef_reload_ctrl.sv
// Scoreboard bench for rx_fir_coef_reload_ctrl: expected reads, writes, pulses and
// busy windows are queued when a request is driven and consumed as the DUT acts.
module tb_rx_fir_coef_reload_ctrl;

  localparam int unsigned NUM_FIR      = 4;
  localparam int unsigned COEF_WIDTH   = 18;
  localparam int unsigned MAX_TAPS     = 64;
  localparam int unsigned ROM_LAT      = 2;
  localparam int unsigned FLUSH_CYCLES = 64;

  typedef struct {
    longint      cyc;
    logic [31:0] val;
  } ev_t;

  typedef struct {
    longint     from;
    longint     to;
    logic [3:0] gate;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic [1:0] sel = '0;
  logic [1:0] set = '0;
  logic [6:0] taps = '0;
  logic busy, done, err, rd;
  logic [9:0] addr;
  logic [COEF_WIDTH-1:0] rom_q = '0;
  logic [NUM_FIR-1:0] ld, we, gate;
  logic [COEF_WIDTH-1:0] din;

  int     n_chk = 0;
  int     n_fail = 0;
  int     wr_seen = 0;
  longint cyc = 0;

  ev_t  rd_q[$];
  ev_t  wr_q[$];
  ev_t  ld_q[$];
  ev_t  done_q[$];
  ev_t  err_q[$];
  win_t win_q[$];

  rx_fir_coef_reload_ctrl #(
    .NUM_FIR(NUM_FIR), .COEF_WIDTH(COEF_WIDTH), .MAX_TAPS(MAX_TAPS),
    .ROM_LAT(ROM_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .logic_clk_in(clk), .logic_rst_n_in(rst_n),
    .reload_req_in(req), .reload_sel_in(sel), .reload_set_in(set), .reload_taps_in(taps),
    .reload_busy_out(busy), .reload_done_out(done), .reload_err_out(err),
    .coef_rom_rd_out(rd), .coef_rom_addr_out(addr), .coef_rom_data_in(rom_q),
    .coef_ld_out(ld), .coef_we_out(we), .coef_din_out(din), .nd_gate_out(gate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One registered ROM stage plus the DUT capture register gives ROM_LAT = 2
  always @(posedge clk) rom_q <= 18'h100 + 18'(addr[5:0]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"},  64'(err),  64'd0);
    check({tag, "_rd"},   64'(rd),   64'd0);
    check({tag, "_addr"}, 64'(addr), 64'd0);
    check({tag, "_ld"},   64'(ld),   64'd0);
    check({tag, "_we"},   64'(we),   64'd0);
    check({tag, "_din"},  64'(din),  64'd0);
    check({tag, "_gate"}, 64'(gate), 64'hF);
  endtask

  task automatic push_reload(input longint t0, input logic [1:0] s, input logic [1:0] st,
                             input int n);
    logic [3:0] oh;
    longint     t_end;
    oh    = 4'b0001 << s;
    t_end = t0 + 2 + n + ROM_LAT + FLUSH_CYCLES;
    ld_q.push_back('{cyc: t0 + 1, val: 32'(oh)});
    for (int k = 0; k < n; k++) begin
      rd_q.push_back('{cyc: t0 + 2 + k, val: 32'({st, s, 6'(k)})});
      wr_q.push_back('{cyc: t0 + 2 + k + ROM_LAT, val: {10'd0, oh, 18'h100 + 18'(k)}});
    end
    done_q.push_back('{cyc: t_end, val: 32'd1});
    win_q.push_back('{from: t0, to: t_end, gate: ~oh});
  endtask

  task automatic do_req(input logic [1:0] s, input logic [1:0] st, input logic [6:0] n,
                        output longint t0);
    @(negedge clk);
    req = 1'b1; sel = s; set = st; taps = n;
    t0 = cyc + 1;
    if (n == 0 || n > 7'(MAX_TAPS)) err_q.push_back('{cyc: t0, val: 32'd1});
    else push_reload(t0, s, st, int'(n));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((done_q.size() != 0 || busy) && n < 400);
    if (n >= 400) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic pop_check(input string tag, inout ev_t q[$], input logic [31:0] obs);
    ev_t e;
    if (q.size() == 0) begin
      check({tag, "_spurious"}, 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      check({tag, "_cyc"}, 64'(cyc), 64'(e.cyc));
      check({tag, "_val"}, 64'(obs), 64'(e.val));
    end
  endtask

  // Monitor: compares everything the DUT produces against the queued expectations
  always @(negedge clk) begin
    logic       exp_busy;
    logic [3:0] exp_gate;
    if (rst_n) begin
      while (win_q.size() > 0 && cyc >= win_q[0].to) win_q.delete(0);
      exp_busy = 1'b0;
      exp_gate = 4'hF;
      if (win_q.size() > 0 && cyc >= win_q[0].from) begin
        exp_busy = 1'b1;
        exp_gate = win_q[0].gate;
      end
      check("busy", 64'(busy), 64'(exp_busy));
      check("gate", 64'(gate), 64'(exp_gate));
      if (rd)   pop_check("rd",   rd_q,   32'(addr));
      if (we != '0) begin
        pop_check("wr", wr_q, {10'd0, we, din});
        wr_seen++;
      end
      if (ld != '0) pop_check("ld",   ld_q,   32'(ld));
      if (done)     pop_check("done", done_q, 32'(done));
      if (err)      pop_check("err",  err_q,  32'(err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t0b;
    int     n;

    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst_rel");

    do_req(2'd1, 2'd2, 7'd8, t0);
    wait_idle();

    do_req(2'd2, 2'd3, 7'd64, t0);
    wait_idle();

    do_req(2'd0, 2'd0, 7'd0, t0);
    wait_idle();
    do_req(2'd3, 2'd1, 7'd65, t0);
    wait_idle();

    // Second request lands in READ of the first and must be ignored
    do_req(2'd0, 2'd1, 7'd8, t0);
    repeat (2) @(negedge clk);
    req = 1'b1; sel = 2'd3; set = 2'd0; taps = 7'd5;
    @(negedge clk);
    req = 1'b0;
    wait_idle();

    // Asynchronous reset between clock edges after three writes
    wr_seen = 0;
    do_req(2'd0, 2'd2, 7'd8, t0);
    n = 0;
    while (wr_seen < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("wr3_timeout", 64'd0, 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_async");
    rd_q.delete(); wr_q.delete(); ld_q.delete(); done_q.delete(); err_q.delete(); win_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(2'd3, 2'd0, 7'd4, t0);
    wait_idle();

    // Request held high across done: next reload starts on the edge after done
    @(negedge clk);
    req = 1'b1; sel = 2'd2; set = 2'd1; taps = 7'd3;
    t0 = cyc + 1;
    push_reload(t0, 2'd2, 2'd1, 3);
    t0b = t0 + 2 + 3 + ROM_LAT + FLUSH_CYCLES + 1;
    push_reload(t0b, 2'd1, 2'd0, 5);
    @(negedge clk);
    sel = 2'd1; set = 2'd0; taps = 7'd5;
    while (cyc < t0b) @(negedge clk);
    req = 1'b0;
    wait_idle();

    repeat (4) @(negedge clk);
    check("rd_left",   64'(rd_q.size()),   64'd0);
    check("wr_left",   64'(wr_q.size()),   64'd0);
    check("ld_left",   64'(ld_q.size()),   64'd0);
    check("done_left", 64'(done_q.size()), 64'd0);
    check("err_left",  64'(err_q.size()),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
